work_seq_ctrl: RTL

- Parametrised start-triggered sequencer. Drives a datapath with clear, load and enable strobes for a programmable number of work cycles.
- Adds four things over the fixed-length controller: runtime length, hold (stall), abort and done/busy status.
- Sits between a user handshake (start level) and any counting or shifting datapath in the tutorial designs.

---
 rtl/work_seq_pkg.sv | 26 ++
 rtl/work_seq_ctrl_counter.sv | 45 ++++
 rtl/work_seq_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/work_seq_pkg.sv
// ============================================================================
// Module  : work_seq_pkg
// Brief   : State encodings shared by the work sequencer and its testbench.
// Revision: 1.0
// ============================================================================
`default_nettype none

package work_seq_pkg;

  localparam int ST_W = 2;

  localparam logic [ST_W-1:0] S_IDLE = 2'b00;
  localparam logic [ST_W-1:0] S_WORK = 2'b01;
  localparam logic [ST_W-1:0] S_DONE = 2'b11;

  // 2'b10 is listed so an upset state register decodes to a named value.
  typedef enum logic [ST_W-1:0] {
    ST_IDLE = S_IDLE,
    ST_WORK = S_WORK,
    ST_BAD  = 2'b10,
    ST_DONE = S_DONE
  } state_e;

endpackage

`default_nettype wire

// File: rtl/work_seq_ctrl_counter.sv
// ============================================================================
// Module  : work_counter
// Brief   : Work-cycle counter with clear/increment and last-cycle compare.
// Revision: 1.0
// ============================================================================
`default_nettype none

module work_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [CNT_W-1:0] len_q_i,
  output logic [CNT_W-1:0] count_o,
  output logic             last_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign last_o  = (count_q == (len_q_i - CNT_W'(1)));

endmodule

`default_nettype wire

// File: rtl/work_seq_ctrl.sv
// ============================================================================
// Module  : work_seq_ctrl
// Brief   : Start-triggered sequencer with runtime length, hold, abort, status.
// Revision: 1.0
// ============================================================================
`default_nettype none

module work_seq_ctrl
  import work_seq_pkg::*;
#(
  parameter int CNT_W     = 4,
  parameter bit RETRIGGER = 1'b0
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic             hold_i,
  input  logic             abort_i,
  output logic             dp_clear_o,
  output logic             dp_load_o,
  output logic             dp_enable_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             aborted_o,
  output logic [CNT_W-1:0] count_o,
  output logic [ST_W-1:0]  state_o
);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] len_d;
  logic             busy_q;
  logic             done_q;
  logic             aborted_q;
  logic             load_d;
  logic             cnt_clr_d;
  logic             cnt_inc_d;
  logic             cnt_last;

  work_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk_i   (clock_i),
    .rst_i   (reset_i),
    .clr_i   (cnt_clr_d),
    .inc_i   (cnt_inc_d),
    .len_q_i (len_q),
    .count_o (count_o),
    .last_o  (cnt_last)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    load_d    = 1'b0;
    cnt_clr_d = 1'b0;
    cnt_inc_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_clr_d = 1'b1;
        if (start_i) begin
          len_d   = len_i;
          load_d  = ~reset_i;
          state_d = (len_i != '0) ? ST_WORK : ST_DONE;
        end
      end
      ST_WORK: begin
        // abort outranks hold, which outranks counting
        if (abort_i) begin
          cnt_clr_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (!hold_i) begin
          cnt_inc_d = 1'b1;
          if (cnt_last) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (RETRIGGER || !start_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      busy_q    <= (state_d == ST_WORK) || (state_d == ST_DONE);
      done_q    <= (state_d == ST_DONE) && (state_q != ST_DONE);
      aborted_q <= (state_q == ST_WORK) && abort_i;
    end
  end

  assign dp_clear_o  = load_d;
  assign dp_load_o   = load_d;
  assign dp_enable_o = load_d | ((state_q == ST_WORK) & ~hold_i);
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign aborted_o   = aborted_q;
  assign state_o     = state_q;

endmodule

`default_nettype wire
